// File: rtl/alu_result_serializer.sv
// Captures ALU results {ctrl, flags, s} into a FIFO and drains them as framed bytes B0..B2 (+B3 XOR checksum with ALU_RESULT_SERIALIZER_CKSUM_EN).
// Latency: record pushed in cycle N shows as B0 with out_valid=1 in cycle N+2 when the FIFO was empty.
// Backpressure: out_data/out_valid hold while out_ready=0; in_ready drops when full and further records are counted as drops.

module alu_result_serializer_fifo #(
  parameter int W     = 24,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_vld,
  input  logic [W-1:0]           push_dat,
  input  logic                   pop_vld,
  output logic [W-1:0]           head_dat,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          wr;
  logic          rd;

  assign full     = (level == LW'(DEPTH));
  assign empty    = (level == '0);
  assign wr       = push_vld && !full;
  assign rd       = pop_vld && !empty;
  assign head_dat = mem[rptr];

  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= push_dat;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (wr) wptr <= wptr + AW'(1);
      if (rd) rptr <= rptr + AW'(1);
      if (wr && !rd)      level <= level + LW'(1);
      else if (rd && !wr) level <= level - LW'(1);
    end
  end
endmodule

module alu_result_serializer #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [3:0]             ctrl,
  input  logic [7:0]             s,
  input  logic [11:0]            flags,
  output logic [7:0]             out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  input  logic                   clr,
  output logic                   overflow,
  output logic [CNT_W-1:0]       drop_cnt,
  output logic [$clog2(DEPTH):0] level
);
  typedef struct packed {
    logic [3:0]  ctrl;
    logic [11:0] flags;
    logic [7:0]  s;
  } rec_t;

`ifdef ALU_RESULT_SERIALIZER_CKSUM_EN
  typedef enum logic [2:0] {IDLE, B0, B1, B2, B3} state_t;
`else
  typedef enum logic [2:0] {IDLE, B0, B1, B2} state_t;
`endif

  rec_t        in_rec;
  rec_t        head;
  logic        empty;
  logic        full;
  logic        push;
  logic        pop;
  logic        drop;
  logic        advance;
  logic        last;
  logic [7:0]  head_b0;
  state_t      state_q;
  state_t      state_d;
  logic [7:0]  out_data_d;
  logic        out_valid_d;
  // Bytes B1/B2 of the frame in flight; B0 goes straight to out_data on pop.
  logic [15:0] tail_q;
`ifdef ALU_RESULT_SERIALIZER_CKSUM_EN
  logic [7:0]  ck_q;
`endif

  assign in_rec   = '{ctrl: ctrl, flags: flags, s: s};
  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign drop     = in_valid && !in_ready;
  assign advance  = out_valid && out_ready;
  assign head_b0  = {head.ctrl, head.flags[11:8]};
`ifdef ALU_RESULT_SERIALIZER_CKSUM_EN
  assign last     = (state_q == B3);
`else
  assign last     = (state_q == B2);
`endif
  // Popping on the final byte's acceptance gives back-to-back frames.
  assign pop      = !empty && ((state_q == IDLE) || (advance && last));

  alu_result_serializer_fifo #(
    .W     ($bits(rec_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push_vld (push),
    .push_dat (in_rec),
    .pop_vld  (pop),
    .head_dat (head),
    .empty    (empty),
    .full     (full),
    .level    (level)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (!empty) state_d = B0;
      B0:   if (advance) state_d = B1;
      B1:   if (advance) state_d = B2;
`ifdef ALU_RESULT_SERIALIZER_CKSUM_EN
      B2:   if (advance) state_d = B3;
      B3:   if (advance) state_d = empty ? IDLE : B0;
`else
      B2:   if (advance) state_d = empty ? IDLE : B0;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_data_d  = out_data;
    out_valid_d = out_valid;
    if (pop) begin
      out_data_d  = head_b0;
      out_valid_d = 1'b1;
    end else if (advance) begin
      case (state_q)
        B0: out_data_d = tail_q[15:8];
        B1: out_data_d = tail_q[7:0];
`ifdef ALU_RESULT_SERIALIZER_CKSUM_EN
        B2: out_data_d = ck_q;
`endif
        default: out_valid_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      tail_q    <= '0;
`ifdef ALU_RESULT_SERIALIZER_CKSUM_EN
      ck_q      <= '0;
`endif
    end else begin
      out_data  <= out_data_d;
      out_valid <= out_valid_d;
      if (pop) begin
        tail_q <= {head.flags[7:0], head.s};
`ifdef ALU_RESULT_SERIALIZER_CKSUM_EN
        ck_q   <= head_b0 ^ head.flags[7:0] ^ head.s;
`endif
      end
    end
  end

  // clr takes priority over a same-cycle drop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (clr) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_alu_result_serializer.sv
// Scoreboard bench for alu_result_serializer: expected frame bytes are queued at push time and compared on each output handshake.
module tb_alu_result_serializer;
  localparam int DEPTH = 8;
  localparam int CNT_W = 8;
`ifdef ALU_RESULT_SERIALIZER_CKSUM_EN
  localparam int FB = 4;
`else
  localparam int FB = 3;
`endif

  logic                   clk;
  logic                   reset;
  logic                   in_valid;
  logic                   in_ready;
  logic [3:0]             ctrl;
  logic [7:0]             s;
  logic [11:0]            flags;
  logic [7:0]             out_data;
  logic                   out_valid;
  logic                   out_ready;
  logic                   clr;
  logic                   overflow;
  logic [CNT_W-1:0]       drop_cnt;
  logic [$clog2(DEPTH):0] level;

  logic [7:0] sb [$];
  int         n_vec = 0;
  int         n_err = 0;
  bit         rnd_run = 0;

  alu_result_serializer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ctrl      (ctrl),
    .s         (s),
    .flags     (flags),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .clr       (clr),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt),
    .level     (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_rec(input logic [3:0] c, input logic [7:0] sv, input logic [11:0] f);
    logic [7:0] b0;
    b0 = {c, f[11:8]};
    sb.push_back(b0);
    sb.push_back(f[7:0]);
    sb.push_back(sv);
`ifdef ALU_RESULT_SERIALIZER_CKSUM_EN
    sb.push_back(b0 ^ f[7:0] ^ sv);
`endif
  endtask

  // Called just after a rising edge; presents one record for exactly one cycle.
  task automatic send(input logic [3:0] c, input logic [7:0] sv, input logic [11:0] f,
                      input bit acc, input string tag);
    ctrl     = c;
    s        = sv;
    flags    = f;
    in_valid = 1'b1;
    check(tag, in_ready, acc);
    if (acc) expect_rec(c, sv, f);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while (sb.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("drain", sb.size(), 0);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      if (sb.size() == 0) check("sb_size", sb.size(), 1);
      else                check("byte", out_data, sb.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; in_valid = 1'b0; ctrl = '0; s = '0; flags = '0;
    out_ready = 1'b0; clr = 1'b0;
    repeat (2) @(posedge clk); #1;
    check("rst_level", level, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_overflow", overflow, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Single record, latency N+2, then gap.
    out_ready = 1'b1;
    send(4'h0, 8'h85, 12'h00A, 1, "t1_rdy");
    @(negedge clk);
    check("t1_lvl_n1", level, 1);
    check("t1_v_n1", out_valid, 0);
    @(negedge clk);
    check("t1_v_n2", out_valid, 1);
    check("t1_b0", out_data, 8'h00);
    for (int i = 1; i < FB; i++) begin
      @(negedge clk);
      check("t1_v_run", out_valid, 1);
    end
    @(negedge clk);
    check("t1_v_end", out_valid, 0);
    drain(20);

    // Back-pressure holds B0.
    out_ready = 1'b0;
    send(4'h3, 8'h44, 12'h801, 1, "t2_rdy");
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t2_hold_v", out_valid, 1);
      check("t2_hold_d", out_data, 8'h38);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain(20);

    // Back-to-back frames without gaps.
    fork
      begin
        send(4'h5, 8'hA1, 12'h123, 1, "t3_rdy");
        send(4'hC, 8'h3C, 12'hFED, 1, "t3_rdy");
        send(4'h9, 8'h00, 12'h0F0, 1, "t3_rdy");
      end
      begin
        int k = 0;
        @(negedge clk);
        while (!out_valid && k < 10) begin
          @(negedge clk);
          k++;
        end
        check("t3_start", out_valid, 1);
        for (int i = 1; i < 3 * FB; i++) begin
          @(negedge clk);
          check("t3_nogap", out_valid, 1);
        end
        @(negedge clk);
        check("t3_end", out_valid, 0);
      end
    join
    drain(20);

    // Fill with a stalled frame in flight, then overflow.
    out_ready = 1'b0;
    send(4'h7, 8'h77, 12'h777, 1, "t4_lead");
    repeat (2) @(negedge clk);
    check("t4_lead_v", out_valid, 1);
    @(posedge clk); #1;
    for (int i = 0; i < DEPTH + 3; i++)
      send(4'(i), 8'(i * 17 + 3), 12'(i * 291 + 5), i < DEPTH, "t4_rdy");
    @(negedge clk);
    check("t4_level", level, DEPTH);
    check("t4_in_ready", in_ready, 0);
    check("t4_overflow", overflow, 1);
    check("t4_drop_cnt", drop_cnt, 3);
    @(posedge clk); #1;
    clr = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("t5_clr_ovf", overflow, 0);
    check("t5_clr_cnt", drop_cnt, 0);
    check("t5_clr_lvl", level, DEPTH);
    @(posedge clk); #1;
    in_valid = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("t5_sat_cnt", drop_cnt, 255);
    check("t5_sat_ovf", overflow, 1);
    check("t5_sat_lvl", level, DEPTH);
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain(200);
    check("t4_lvl_end", level, 0);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    check("t5_clr2_ovf", overflow, 0);
    check("t5_clr2_cnt", drop_cnt, 0);

    // Random records with random sink stalls.
    rnd_run = 1'b1;
    fork
      begin
        for (int r = 0; r < 20; r++) begin
          send(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
               12'($urandom_range(0, 4095)), 1, "t7_rdy");
          repeat (4) @(posedge clk);
          #1;
        end
        rnd_run = 1'b0;
      end
      begin
        while (rnd_run) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain(200);

    // Reset during B1 with two records queued.
    out_ready = 1'b0;
    send(4'hA, 8'h5A, 12'hB3C, 1, "t6_rdy");
    send(4'h1, 8'h11, 12'h222, 1, "t6_rdy");
    send(4'h2, 8'h33, 12'h444, 1, "t6_rdy");
    @(negedge clk);
    check("t6_lvl", level, 2);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("t6_b1_v", out_valid, 1);
    check("t6_b1_d", out_data, 8'h3C);
    #2;
    reset = 1'b0;
    #1;
    check("t6_rst_v", out_valid, 0);
    check("t6_rst_lvl", level, 0);
    check("t6_rst_rdy", in_ready, 1);
    check("t6_rst_d", out_data, 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t6_quiet", out_valid, 0);
    end
    @(posedge clk); #1;
    send(4'hF, 8'hE7, 12'h9D2, 1, "t6_new");
    drain(20);

    check("sb_final", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
